// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: write-back source codes and architected register indices.
package mips_pkg;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
  localparam logic [1:0] MEMTOREG_LINK = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_bypass_port.sv
// One register-file read port: r0 forced to zero, same-cycle bypass of the retiring WB value.
module regfile_bypass_port
  import mips_pkg::*;
(
  input  logic [4:0]  addr_i,
  input  logic [31:0] stored_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_idx_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = stored_i;
    if (addr_i == REG_ZERO)
      data_o = '0;
    else if (wb_en_i && (addr_i == wb_idx_i))
      data_o = wb_data_i;
  end

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: source select, 32x32 register file commit, retire counter, two bypassed read ports.
module wb_regfile
  import mips_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_0000,
  parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iRegWr,
  input  logic [1:0]  iMemToReg,
  input  logic [31:0] iALUResult,
  input  logic [31:0] iReadData,
  input  logic [31:0] iNextPC,
  input  logic [4:0]  iRegDst,
  input  logic [4:0]  iRsAddr,
  input  logic [4:0]  iRtAddr,
  output logic [31:0] oRsData,
  output logic [31:0] oRtData,
  output logic [31:0] oWbData,
  output logic        oWbEn,
  output logic [31:0] oRetireCnt
);

  logic [31:0] regs_q [32];
  logic [31:0] retire_cnt_q;

  // Reserved code 2'b11 falls back to the ALU result silently.
  always_comb begin
    unique case (iMemToReg)
      MEMTOREG_MEM:  oWbData = iReadData;
      MEMTOREG_LINK: oWbData = iNextPC;
      default:       oWbData = iALUResult;
    endcase
  end

  assign oWbEn = iRegWr && (iRegDst != REG_ZERO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      regs_q[REG_GP] <= GP_INIT;
      regs_q[REG_SP] <= SP_INIT;
      retire_cnt_q   <= '0;
    end else if (oWbEn) begin
      regs_q[iRegDst] <= oWbData;
      retire_cnt_q    <= retire_cnt_q + 32'd1;
    end
  end

  assign oRetireCnt = retire_cnt_q;

  regfile_bypass_port u_rs_port (
    .addr_i    (iRsAddr),
    .stored_i  (regs_q[iRsAddr]),
    .wb_en_i   (oWbEn),
    .wb_idx_i  (iRegDst),
    .wb_data_i (oWbData),
    .data_o    (oRsData)
  );

  regfile_bypass_port u_rt_port (
    .addr_i    (iRtAddr),
    .stored_i  (regs_q[iRtAddr]),
    .wb_en_i   (oWbEn),
    .wb_idx_i  (iRegDst),
    .wb_data_i (oWbData),
    .data_o    (oRtData)
  );

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file for the five-stage MIPS pipeline. Consumes the registered MEM/WB outputs, selects the write-back value, commits it to a 32 x 32-bit register file on the clock edge, and serves the two ID-stage read ports. Same-cycle write-to-read bypass means an instruction in ID always sees the value being retired in WB, with no extra forwarding path.

## Interface

Parameters:
- `SP_INIT`, default 32'h0000_0000: reset value of register 29 ($sp).
- `GP_INIT`, default 32'h0000_0000: reset value of register 28 ($gp).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clock `clk`.
- `iRegWr`  in  1  write enable from MEM/WB.
- `iMemToReg`  in  2  write-back source select from MEM/WB.
- `iALUResult`  in  32  ALU result from MEM/WB.
- `iReadData`  in  32  data-memory load value from MEM/WB.
- `iNextPC`  in  32  link address (PC+4) from MEM/WB.
- `iRegDst`  in  5  destination register index; upper bits of the 32-bit MEM/WB field are ignored.
- `iRsAddr`  in  5  ID read port A index.
- `iRtAddr`  in  5  ID read port B index.
- `oRsData`  out  32  read port A data.
- `oRtData`  out  32  read port B data.
- `oWbData`  out  32  selected write-back value, for EX-stage forwarding.
- `oWbEn`  out  1  effective write strobe: `iRegWr` and `iRegDst` != 0.
- `oRetireCnt`  out  32  count of committed register writes.

## Operation

- Write-back select:
  - `iMemToReg` 00: `iALUResult`.
  - 01: `iReadData`.
  - 10: `iNextPC`.
  - 11: `iALUResult`. This code is reserved and must not assert an error.
- Commit: on a rising edge with `oWbEn`=1, reg[`iRegDst`] <= `oWbData`.
- Register 0 is hardwired to zero. A write to index 0 is dropped and does not increment `oRetireCnt`. Reads of index 0 always return 0.
- Read ports are combinational from the array, with a bypass: if `oWbEn`=1 and the read index equals `iRegDst`, the port returns `oWbData` instead of the stored value. The bypass applies to both ports independently and simultaneously.
- `oRetireCnt` increments by 1 on every committed write and wraps from 32'hFFFF_FFFF to 0.
- Reset (`reset`=0, asynchronous):
  - all registers cleared to 0, except reg 28 = `GP_INIT` and reg 29 = `SP_INIT`.
  - `oRetireCnt` = 0.
  - writes are suppressed while `reset` is low, even if `iRegWr`=1.
- Reset values of the combinational outputs follow from the cleared state: `oRsData`/`oRtData` return 0 (or the init value for indices 28/29). `oWbData` and `oWbEn` follow their inputs; upstream MEM/WB drives `iRegWr`=0 during reset.
- Reset asserted mid-operation aborts any pending write. After deassertion the first commit happens on the first rising edge with `oWbEn`=1.

## Timing

- Write latency is one edge. The value is visible from the stored array in the cycle after the commit edge, and visible through the bypass in the same cycle it is presented.
- Read paths are zero-cycle combinational: address to data through the bypass mux.
- No handshake and no stall input. MEM/WB is the sole producer, and one write per cycle is guaranteed.
- Back-to-back writes to the same index: the last edge wins. The bypass always reflects the current-cycle WB value.
- Both read ports addressing the write index at once: both return `oWbData`.

## Structure

- Shared package `mips_pkg`:
  - `MEMTOREG_ALU`=2'b00, `MEMTOREG_MEM`=2'b01, `MEMTOREG_LINK`=2'b10
  - `REG_ZERO`=5'd0, `REG_GP`=5'd28, `REG_SP`=5'd29, `REG_RA`=5'd31
- One sub-module is natural: `regfile_bypass_port`. It handles a single read port with the zero check and bypass compare, and is instantiated twice.
- The write-back select mux, the array, and the retire counter live in the top module.

## Test plan

- Reset with `SP_INIT`=32'h0000_7FFC: read r29 -> 32'h0000_7FFC; read r5 -> 0; `oRetireCnt`=0.
- Write each source: `iRegWr`=1, dst=8.
  - `iMemToReg`=00, ALU=32'h1234 -> r8 = 32'h1234 after the edge.
  - 01, ReadData=32'hDEAD_BEEF -> r8 = 32'hDEAD_BEEF.
  - 10, NextPC=32'h0040_0008 into dst=31 -> r31 = 32'h0040_0008.
- Bypass: dst=9, ALU=32'hA5A5, `iRsAddr`=`iRtAddr`=9 in the same cycle -> both ports read 32'hA5A5 before the edge.
- Zero register: `iRegWr`=1, dst=0, ALU=32'hFFFF -> `oWbEn`=0; r0 reads 0, including the bypass case; `oRetireCnt` unchanged.
- Mid-operation reset: write r10=5, then pulse `reset` low between edges -> r10 reads 0 and `oRetireCnt`=0. A write presented during reset is not committed.
- Counter wrap: force `oRetireCnt` to 32'hFFFF_FFFF, commit one write -> `oRetireCnt`=0.
